ex_mem_pipe: RTL and testbench
==============================

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 Parameter DATA_W, default 16, datapath width of all address/data fields.
REQ-002 Parameter REG_AW, default 3, width of destination register index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 stall  input  1  hold all captured state this cycle.
REQ-006 flush  input  1  replace captured instruction with a bubble.
REQ-007 valid_in  input  1  execute stage presents a real instruction.
REQ-008 zero_in, ltz_in  input  1 each  ALU flags for branch resolution.
REQ-009 Branch_in  input  1  instruction is a conditional branch.
REQ-010 branch_op_in  input  2  branch condition select (00 eq, 01 ne, 10 lt, 11 ge).
REQ-011 branchAddr_in, jumpaddr_in  input  DATA_W each  target addresses.
REQ-012 MemRead_in, MemWrite_in  input  1 each  memory access controls.
REQ-013 ALU_result_in, writedata_in  input  DATA_W each  address/data operands.
REQ-014 RegWrite_in, MemToReg_in  input  1 each  writeback controls; writeReg_in  input  REG_AW  destination index.
REQ-015 halt_in  input  1  instruction is HALT.
REQ-016 Outputs: same names with suffix _out, same widths, plus valid_out (1) and halted (1); all driven directly from registers or register-AND-valid.

Function
REQ-017 Capture: when state RUN, ~stall, ~flush, all *_in fields SHALL load into registers at clock edge; valid register loads valid_in.
REQ-018 Stall: when stall=1 and flush=0, all registers SHALL hold; outputs unchanged.
REQ-019 Flush: when flush=1, valid register SHALL clear regardless of stall; data fields may load or hold (don't-care).
REQ-020 Qualified controls: Branch_out, MemRead_out, MemWrite_out, RegWrite_out, halt_out SHALL equal stored bit AND valid register; latency from input to output one cycle.
REQ-021 FSM states RUN, HALTED; encoding 1 bit.
REQ-022 RUN->HALTED when an instruction with halt_in=1 and valid_in=1 is captured (REQ-017 conditions); transition same edge as capture.
REQ-023 In HALTED: no further capture, stall/flush ignored, all registers held, halt_out held 1, halted=1; exit only by rst.
REQ-024 Flush and halt capture in same cycle: flush wins, no transition.
REQ-025 halt_in with valid_in=0 SHALL be ignored.
REQ-026 Data widths pass through unmodified; no arithmetic performed.

Reset
REQ-027 On rst=1 at clock edge: state RUN, valid register 0, every data/control register 0, therefore every output 0 and halted=0.
REQ-028 rst SHALL override stall, flush and HALTED state in the same cycle.
REQ-029 Reset mid-operation discards the captured instruction; first capture occurs on the first edge with rst=0.

Structure
REQ-030 Shared package holds DATA_W/REG_AW defaults, FSM state constants and branch_op codes (BR_EQ, BR_NE, BR_LT, BR_GE).
REQ-031 One sub-module: pipe_reg (parameterised width, synchronous rst, enable, clear-to-zero) instanced per field group.

Verification
REQ-032 Capture: valid_in=1, ALU_result_in=16'h1234, MemRead_in=1, writeReg_in=3 -> next cycle ALU_result_out=16'h1234, MemRead_out=1, writeReg_out=3, valid_out=1.
REQ-033 Stall: capture 16'h00AA, hold stall=1 for 3 cycles with ALU_result_in=16'h5555 -> output remains 16'h00AA all 3 cycles, valid_out=1.
REQ-034 Flush+stall: captured MemWrite=1; assert flush=1 and stall=1 -> next cycle valid_out=0, MemWrite_out=0.
REQ-035 Halt: valid_in=1, halt_in=1 -> next cycle halt_out=1, halted=1; following 5 cycles with new inputs and flush pulses -> all outputs unchanged.
REQ-036 Reset: in HALTED with stall=1, assert rst one cycle -> next cycle all outputs 0, halted=0; next valid_in=1, writedata_in=16'hBEEF -> writedata_out=16'hBEEF.
REQ-037 Invalid halt: valid_in=0, halt_in=1 -> halted stays 0, halt_out=0.

Source files
------------

// File: rtl/ex_mem_pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline register: default widths,
// FSM state encoding, branch condition codes and the packed control bundle.
package ex_mem_pipe_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 3;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    localparam logic [1:0] BR_EQ = 2'b00;
    localparam logic [1:0] BR_NE = 2'b01;
    localparam logic [1:0] BR_LT = 2'b10;
    localparam logic [1:0] BR_GE = 2'b11;

    // Single-bit and narrow control fields travel together through one register.
    typedef struct packed {
        logic       zero;
        logic       ltz;
        logic       branch;
        logic [1:0] branch_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       halt;
    } ctrl_t;

endpackage

// File: rtl/ex_mem_pipe_reg.sv
// Generic pipeline register: synchronous reset, clear-to-zero, load enable.
// Priority is rst > clr > en; with none asserted the register holds.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // NOTE: the hold value is the default, so no path leaves data_d unassigned and no latch is inferred.
    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = '0;
        end else if (en) begin
            data_d = d;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with stall, flush-to-bubble and a sticky HALTED
// state entered when a valid HALT instruction is captured.
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              zero_in,
    input  logic              ltz_in,
    input  logic              Branch_in,
    input  logic [1:0]        branch_op_in,
    input  logic [DATA_W-1:0] branchAddr_in,
    input  logic [DATA_W-1:0] jumpaddr_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] writedata_in,
    input  logic              RegWrite_in,
    input  logic              MemToReg_in,
    input  logic [REG_AW-1:0] writeReg_in,
    input  logic              halt_in,
    output logic              valid_out,
    output logic              zero_out,
    output logic              ltz_out,
    output logic              Branch_out,
    output logic [1:0]        branch_op_out,
    output logic [DATA_W-1:0] branchAddr_out,
    output logic [DATA_W-1:0] jumpaddr_out,
    output logic              MemRead_out,
    output logic              MemWrite_out,
    output logic [DATA_W-1:0] ALU_result_out,
    output logic [DATA_W-1:0] writedata_out,
    output logic              RegWrite_out,
    output logic              MemToReg_out,
    output logic [REG_AW-1:0] writeReg_out,
    output logic              halt_out,
    output logic              halted
);

    state_e state_q, state_d;
    logic   running;
    logic   capture;
    logic   valid_clr;
    logic   valid_q;

    ctrl_t                ctrl_in;
    ctrl_t                ctrl_q;
    logic [2*DATA_W-1:0]  addr_q;
    logic [2*DATA_W-1:0]  data_q;
    logic [REG_AW-1:0]    wreg_q;

    // HALTED freezes everything, so stall and flush only matter while running.
    assign running   = (state_q == ST_RUN);
    assign capture   = running & ~stall & ~flush;
    assign valid_clr = running & flush;

    always_comb begin
        state_d = state_q;
        if (capture && valid_in && halt_in) begin
            state_d = ST_HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctrl_in            = '0;
        ctrl_in.zero       = zero_in;
        ctrl_in.ltz        = ltz_in;
        ctrl_in.branch     = Branch_in;
        ctrl_in.branch_op  = branch_op_in;
        ctrl_in.mem_read   = MemRead_in;
        ctrl_in.mem_write  = MemWrite_in;
        ctrl_in.reg_write  = RegWrite_in;
        ctrl_in.mem_to_reg = MemToReg_in;
        ctrl_in.halt       = halt_in;
    end

    pipe_reg #(.W(1)) u_valid (
        .clk (clk),
        .rst (rst),
        .en  (capture),
        .clr (valid_clr),
        .d   (valid_in),
        .q   (valid_q)
    );

    pipe_reg #(.W($bits(ctrl_t))) u_ctrl (
        .clk (clk),
        .rst (rst),
        .en  (capture),
        .clr (1'b0),
        .d   (ctrl_in),
        .q   (ctrl_q)
    );

    pipe_reg #(.W(2*DATA_W)) u_addr (
        .clk (clk),
        .rst (rst),
        .en  (capture),
        .clr (1'b0),
        .d   ({branchAddr_in, jumpaddr_in}),
        .q   (addr_q)
    );

    pipe_reg #(.W(2*DATA_W)) u_data (
        .clk (clk),
        .rst (rst),
        .en  (capture),
        .clr (1'b0),
        .d   ({ALU_result_in, writedata_in}),
        .q   (data_q)
    );

    pipe_reg #(.W(REG_AW)) u_wreg (
        .clk (clk),
        .rst (rst),
        .en  (capture),
        .clr (1'b0),
        .d   (writeReg_in),
        .q   (wreg_q)
    );

    // Side-effecting controls are gated by valid so a bubble can never act.
    assign valid_out      = valid_q;
    assign Branch_out     = ctrl_q.branch    & valid_q;
    assign MemRead_out    = ctrl_q.mem_read  & valid_q;
    assign MemWrite_out   = ctrl_q.mem_write & valid_q;
    assign RegWrite_out   = ctrl_q.reg_write & valid_q;
    assign halt_out       = ctrl_q.halt      & valid_q;
    assign zero_out       = ctrl_q.zero;
    assign ltz_out        = ctrl_q.ltz;
    assign branch_op_out  = ctrl_q.branch_op;
    assign MemToReg_out   = ctrl_q.mem_to_reg;
    assign branchAddr_out = addr_q[2*DATA_W-1:DATA_W];
    assign jumpaddr_out   = addr_q[DATA_W-1:0];
    assign ALU_result_out = data_q[2*DATA_W-1:DATA_W];
    assign writedata_out  = data_q[DATA_W-1:0];
    assign writeReg_out   = wreg_q;
    assign halted         = (state_q == ST_HALTED);

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_ex_mem_pipe;

    typedef struct packed {
        logic        zero;
        logic        ltz;
        logic        br;
        logic [1:0]  bop;
        logic [15:0] baddr;
        logic [15:0] jaddr;
        logic        mr;
        logic        mw;
        logic [15:0] alu;
        logic [15:0] wd;
        logic        rw;
        logic        m2r;
        logic [2:0]  wr;
        logic        halt;
    } fields_t;

    logic        clk = 1'b0;
    logic        rst, stall, flush, valid_in, zero_in, ltz_in, Branch_in;
    logic [1:0]  branch_op_in;
    logic [15:0] branchAddr_in, jumpaddr_in, ALU_result_in, writedata_in;
    logic        MemRead_in, MemWrite_in, RegWrite_in, MemToReg_in, halt_in;
    logic [2:0]  writeReg_in;

    logic        valid_out, zero_out, ltz_out, Branch_out;
    logic [1:0]  branch_op_out;
    logic [15:0] branchAddr_out, jumpaddr_out, ALU_result_out, writedata_out;
    logic        MemRead_out, MemWrite_out, RegWrite_out, MemToReg_out, halt_out, halted;
    logic [2:0]  writeReg_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_mem_pipe #(.DATA_W(16), .REG_AW(3)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .zero_in(zero_in), .ltz_in(ltz_in), .Branch_in(Branch_in), .branch_op_in(branch_op_in),
        .branchAddr_in(branchAddr_in), .jumpaddr_in(jumpaddr_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .ALU_result_in(ALU_result_in), .writedata_in(writedata_in),
        .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in), .writeReg_in(writeReg_in),
        .halt_in(halt_in),
        .valid_out(valid_out), .zero_out(zero_out), .ltz_out(ltz_out), .Branch_out(Branch_out),
        .branch_op_out(branch_op_out), .branchAddr_out(branchAddr_out), .jumpaddr_out(jumpaddr_out),
        .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
        .ALU_result_out(ALU_result_out), .writedata_out(writedata_out),
        .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out), .writeReg_out(writeReg_out),
        .halt_out(halt_out), .halted(halted)
    );

    fields_t in_s, out_s;
    assign in_s  = {zero_in, ltz_in, Branch_in, branch_op_in, branchAddr_in, jumpaddr_in,
                    MemRead_in, MemWrite_in, ALU_result_in, writedata_in,
                    RegWrite_in, MemToReg_in, writeReg_in, halt_in};
    assign out_s = {zero_out, ltz_out, Branch_out, branch_op_out, branchAddr_out, jumpaddr_out,
                    MemRead_out, MemWrite_out, ALU_result_out, writedata_out,
                    RegWrite_out, MemToReg_out, writeReg_out, halt_out};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the stage must be holding after each edge.
    fields_t m_f;
    logic    m_valid, m_halted, m_known;
    logic    m_init = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_f = '0; m_valid = 1'b0; m_halted = 1'b0; m_known = 1'b1; m_init = 1'b1;
        end else if (m_init && !m_halted) begin
            if (flush) begin
                m_valid = 1'b0;
                m_known = 1'b0;
            end else if (!stall) begin
                m_f     = in_s;
                m_valid = valid_in;
                m_known = 1'b1;
                if (valid_in && halt_in) m_halted = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        fields_t e;
        if (m_init) begin
            e = m_f;
            e.br   = m_f.br   & m_valid;
            e.mr   = m_f.mr   & m_valid;
            e.mw   = m_f.mw   & m_valid;
            e.rw   = m_f.rw   & m_valid;
            e.halt = m_f.halt & m_valid;
            if (m_known) check("model_fields", out_s, e);
            else check("model_qual", {out_s.br, out_s.mr, out_s.mw, out_s.rw, out_s.halt},
                       {e.br, e.mr, e.mw, e.rw, e.halt});
            check("model_valid", valid_out, m_valid);
            check("model_halted", halted, m_halted);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {zero_in, ltz_in, Branch_in, branch_op_in, branchAddr_in, jumpaddr_in,
         MemRead_in, MemWrite_in, ALU_result_in, writedata_in,
         RegWrite_in, MemToReg_in, writeReg_in, halt_in} = '0;
        valid_in = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic rand_fields();
        {zero_in, ltz_in, Branch_in, branch_op_in} = 5'($urandom);
        branchAddr_in = 16'($urandom);
        jumpaddr_in   = 16'($urandom);
        ALU_result_in = 16'($urandom);
        writedata_in  = 16'($urandom);
        {MemRead_in, MemWrite_in, RegWrite_in, MemToReg_in} = 4'($urandom);
        writeReg_in   = 3'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();
        check("reset_fields", out_s, '0);
        check("reset_valid", valid_out, 1'b0);
        check("reset_halted", halted, 1'b0);

        // Basic capture
        rst = 1'b0;
        valid_in = 1'b1; ALU_result_in = 16'h1234; MemRead_in = 1'b1; writeReg_in = 3'd3;
        tick();
        check("cap_alu", ALU_result_out, 16'h1234);
        check("cap_memread", MemRead_out, 1'b1);
        check("cap_wreg", writeReg_out, 3'd3);
        check("cap_valid", valid_out, 1'b1);

        // Stall holds for three cycles
        MemRead_in = 1'b0; ALU_result_in = 16'h00AA;
        tick();
        stall = 1'b1; ALU_result_in = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_alu", ALU_result_out, 16'h00AA);
            check("stall_valid", valid_out, 1'b1);
        end

        // Flush wins over stall
        stall = 1'b0; MemWrite_in = 1'b1;
        tick();
        check("pre_flush_memwrite", MemWrite_out, 1'b1);
        flush = 1'b1; stall = 1'b1;
        tick();
        check("flush_valid", valid_out, 1'b0);
        check("flush_memwrite", MemWrite_out, 1'b0);
        flush = 1'b0; stall = 1'b0; MemWrite_in = 1'b0;

        // Halt without valid is ignored
        valid_in = 1'b0; halt_in = 1'b1;
        tick();
        check("inv_halt_halted", halted, 1'b0);
        check("inv_halt_out", halt_out, 1'b0);

        // Flush blocks a halt capture
        valid_in = 1'b1; flush = 1'b1;
        tick();
        check("flush_halt_halted", halted, 1'b0);
        flush = 1'b0;

        // Valid halt freezes the stage
        ALU_result_in = 16'h0C0C;
        tick();
        check("halt_out", halt_out, 1'b1);
        check("halt_halted", halted, 1'b1);
        for (int i = 0; i < 5; i++) begin
            rand_fields();
            valid_in = 1'b1; halt_in = 1'b0;
            flush = (i % 2 == 0); stall = 1'b0;
            tick();
            check("halted_alu", ALU_result_out, 16'h0C0C);
            check("halted_halt_out", halt_out, 1'b1);
            check("halted_valid", valid_out, 1'b1);
            check("halted_state", halted, 1'b1);
        end

        // Reset overrides HALTED and stall
        stall = 1'b1; flush = 1'b0; rst = 1'b1;
        tick();
        check("rst_halted_fields", out_s, '0);
        check("rst_halted_valid", valid_out, 1'b0);
        check("rst_halted_state", halted, 1'b0);
        rst = 1'b0;
        clear_inputs();
        valid_in = 1'b1; writedata_in = 16'hBEEF;
        tick();
        check("post_rst_wd", writedata_out, 16'hBEEF);

        // Randomized traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            rand_fields();
            valid_in = ($urandom_range(0, 3) != 0);
            halt_in  = ($urandom_range(0, 49) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            rst      = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
